// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
package riscv_pkg;

    // Control FSM states, one per step of the multicycle sequence.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_TRAP     = 4'd10
    } mc_state_t;

    // Supported major opcodes (instruction bits [6:0]).
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ALUOp codes understood by the ALU control decoder.
    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    // ALU operand A sources.
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B sources.
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Writeback / PC-next result sources.
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    // Raw control word produced by the output decoder, before reset gating.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       illegal;
        logic       retire;
    } mc_ctrl_t;

    // Decode-time dispatch: which state follows DECODE for a given opcode.
    function automatic mc_state_t dispatch(input logic [6:0] opc);
        mc_state_t nxt;
        case (opc)
            OPC_LOAD,
            OPC_STORE:  nxt = S_MEMADR;
            OPC_RTYPE:  nxt = S_EXECR;
            OPC_ITYPE:  nxt = S_EXECI;
            OPC_BRANCH: nxt = S_BEQ;
            default:    nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational map from (state, mem_ready) to the raw datapath control word.
module mc_output_decode
    import riscv_pkg::*;
(
    input  mc_state_t state,
    input  logic      mem_ready,
    output mc_ctrl_t  ctrl
);

    // Moore decode per state; only the FETCH enables and the store retire
    // depend on mem_ready so that side effects happen on the completing cycle.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURES;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_update  = mem_ready;
            end
            S_DECODE: begin
                // Branch target PC+imm is parked in ALUOut for a possible BEQ.
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_MEMDATA;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_req    = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.adr_src    = 1'b1;
                ctrl.retire     = mem_ready;
            end
            S_EXECR: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_R;
            end
            S_EXECI: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALUOP_I;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_BEQ: begin
                // Compare rs1-rs2; PC takes ALUOut (the target) when zero.
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_TRAP: begin
                ctrl.illegal    = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I core: state register, next-state
// logic and reset gating of the decoded control outputs.
module multicycle_control
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       illegal,
    output logic       retire
);

    mc_state_t state;
    mc_state_t state_next;
    mc_ctrl_t  ctrl;

    // State register; reset restarts at FETCH, abandoning any instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; memory states hold until mem_ready, TRAP holds forever.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE:   state_next = dispatch(opcode);
            S_MEMADR: begin
                if (opcode == OPC_LOAD) begin
                    state_next = S_MEMREAD;
                end else if (opcode == OPC_STORE) begin
                    state_next = S_MEMWRITE;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_TRAP;
        endcase
    end

    mc_output_decode u_output_decode (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // Drive ports from the decoded word; everything is held at 0 while rst is high.
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        illegal    = 1'b0;
        retire     = 1'b0;
        if (!rst) begin
            mem_req    = ctrl.mem_req;
            mem_write  = ctrl.mem_write;
            adr_src    = ctrl.adr_src;
            ir_write   = ctrl.ir_write;
            pc_write   = ctrl.pc_update | (ctrl.branch & zero);
            reg_write  = ctrl.reg_write;
            alu_src_a  = ctrl.alu_src_a;
            alu_src_b  = ctrl.alu_src_b;
            alu_op     = ctrl.alu_op;
            result_src = ctrl.result_src;
            illegal    = ctrl.illegal;
            retire     = ctrl.retire;
        end
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle variant of the RV32I core. It sequences the shared ALU, register file, instruction/data memory port and PC through the fetch/decode/execute/memory/writeback steps, one instruction at a time. It drives the 2-bit `alu_op` consumed by the existing ALU control decoder, plus all datapath mux selects and write enables. It supports lw, sw, R-type (add/sub/and/or/slt), addi and beq, and traps on any other opcode.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: instruction register bits [6:0]; valid from DECODE onward.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access in this cycle.
- `mem_req` out 1: memory access requested.
- `mem_write` out 1: requested access is a write.
- `adr_src` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load IR and OldPC.
- `pc_write` out 1: load PC; equals `pc_update | (branch & zero)`.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 2: ALU A select; 00 = PC, 01 = OldPC, 10 = rs1 data.
- `alu_src_b` out 2: ALU B select; 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = R-type, 11 = I-type.
- `result_src` out 2: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- `illegal` out 1: sticky, high while in TRAP.
- `retire` out 1: one-cycle pulse when an instruction completes.

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, TRAP.

Outputs are Moore-decoded from the state, except the FETCH enables and `retire`, which are gated by `mem_ready`. Any output not listed for a state is 0.

- **FETCH:** `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10.
  - `ir_write` and `pc_update` are 1 only when `mem_ready`=1.
  - Go to DECODE on `mem_ready`; otherwise hold.
- **DECODE:** `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (computes the branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - anything else → TRAP
- **MEMADR:** `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Next: MEMREAD if the opcode is lw, MEMWRITE if sw.
- **MEMREAD:** `mem_req`=1, `adr_src`=1. Go to MEMWB on `mem_ready`.
- **MEMWB:** `result_src`=01, `reg_write`=1, `retire`=1. Go to FETCH.
- **MEMWRITE:** `mem_req`=1, `mem_write`=1, `adr_src`=1. On `mem_ready`: `retire`=1, go to FETCH.
- **EXECR:** `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Go to ALUWB.
- **EXECI:** `alu_src_a`=10, `alu_src_b`=01, `alu_op`=11. Go to ALUWB.
- **ALUWB:** `result_src`=00, `reg_write`=1, `retire`=1. Go to FETCH.
- **BEQ:** `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `branch`=1, `retire`=1. Go to FETCH.
- **TRAP:** `illegal`=1, all enables 0. Only `rst` leaves this state.

## Timing
- **Reset:** `rst` is sampled at the rising edge.
  - Next state is FETCH.
  - While `rst` is high, every output is forced to 0, including `mem_req` and all selects.
  - Reset mid-instruction abandons the instruction with no register or memory write.
  - `illegal` clears.
- **Zero-wait memory** (`mem_ready` tied high): lw = 5 cycles, sw = 4, R-type/addi = 4, beq = 3. Each wait cycle adds 1.
- **Handshake:**
  - `mem_req`, `mem_write` and `adr_src` stay stable while waiting.
  - `mem_ready` is ignored when `mem_req`=0.
  - A write is considered committed in the cycle in which `mem_req`, `mem_write` and `mem_ready` are all 1.
- **beq:** `zero` is sampled in the BEQ cycle only. `pc_write` in that cycle equals `zero`.
- **retire:** exactly one pulse per completed instruction. Never asserted for a trapped opcode.

## Structure
- Shared package `riscv_pkg`:
  - state enum `mc_state_t`
  - opcode constants `OPC_LOAD`, `OPC_STORE`, `OPC_RTYPE`, `OPC_ITYPE`, `OPC_BRANCH`
  - ALUOp constants `ALUOP_ADD`, `ALUOP_SUB`, `ALUOP_R`, `ALUOP_I`
  - select encodings `SRCA_*`, `SRCB_*`, `RES_*`
- Split into the state register/next-state logic plus one combinational sub-module, `mc_output_decode`, mapping (state, `mem_ready`) to outputs.

## Test plan
- Reset with `mem_ready`=1, `opcode`=0110011 → all outputs 0 while `rst`=1. The first cycle after reset is FETCH with `ir_write`=`pc_write`=1. `retire` pulses in cycle 4, then the next FETCH starts.
- lw (0000011) with `mem_ready` low for 2 cycles in FETCH and 3 in MEMREAD → `mem_req`/`adr_src` held steady throughout. `reg_write` with `result_src`=01 occurs exactly once. Total 10 cycles.
- sw (0100011), zero wait → `mem_write`=1 and `adr_src`=1 in cycle 4. `reg_write` never asserted.
- beq (1100011) with `zero`=1, then a second beq with `zero`=0 → `pc_write`=1 in the BEQ cycle only for the first. `alu_op`=01 in both.
- addi (0010011) → EXECI cycle shows `alu_op`=11, `alu_src_b`=01. Then `reg_write`, `result_src`=00.
- `opcode`=1111111 → TRAP on cycle 3; `illegal` stays high for 20 cycles with no enables. Asserting `rst` then returns to FETCH with `illegal`=0.
